// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Common-data-bus producer; per-source FIFOs for ALU and LSB
//            results with round-robin single-broadcast arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int ROB_SIZE_LOG   = 4,
   parameter int FIFO_DEPTH_LOG = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    jump_rst,
   input  logic                    alu_send,
   input  logic [31:0]             alu_value,
   input  logic [ROB_SIZE_LOG-1:0] alu_reorder,
   input  logic                    lsb_send,
   input  logic [31:0]             lsb_value,
   input  logic [ROB_SIZE_LOG-1:0] lsb_reorder,
   output logic                    alu_full,
   output logic                    lsb_full,
   output logic                    commit_send,
   output logic [31:0]             commit_value,
   output logic [ROB_SIZE_LOG-1:0] commit_reorder,
   output logic                    overflow
);

   localparam int c_DEPTH = 1 << FIFO_DEPTH_LOG;
   localparam int c_EW    = 32 + ROB_SIZE_LOG;
   localparam logic [FIFO_DEPTH_LOG-1:0] c_PTR_ONE = FIFO_DEPTH_LOG'(1);
   localparam logic [FIFO_DEPTH_LOG:0]   c_CNT_ONE = (FIFO_DEPTH_LOG+1)'(1);

   // Index 0 is the ALU source, index 1 the LSB source.
   logic [1:0]      send_w;
   logic [c_EW-1:0] in_w   [2];
   logic [c_EW-1:0] head_w [2];
   logic [1:0]      has_w, full_w, cand_w, grant_w, pop_w, push_req_w, push_w, drop_w;
   logic            active_w;
   logic [c_EW-1:0] sel_w;

   logic                    commit_send_q;
   logic [31:0]             commit_value_q;
   logic [ROB_SIZE_LOG-1:0] commit_reorder_q;
   logic                    overflow_q;
   logic                    last_q, last_d;   // 1: LSB was granted most recently

   assign send_w = {lsb_send, alu_send};
   assign in_w[0] = {alu_value, alu_reorder};
   assign in_w[1] = {lsb_value, lsb_reorder};

   for (genvar s = 0; s < 2; s++) begin : g_fifo
      logic [c_EW-1:0]           mem_q [c_DEPTH];
      logic [FIFO_DEPTH_LOG-1:0] head_q, tail_q;
      logic [FIFO_DEPTH_LOG:0]   cnt_q;

      assign has_w[s]  = (cnt_q != '0);
      // Count never exceeds DEPTH, so its top bit alone marks full.
      assign full_w[s] = cnt_q[FIFO_DEPTH_LOG];
      assign head_w[s] = mem_q[head_q];

      always_ff @(posedge clk) begin
         if (push_w[s]) mem_q[tail_q] <= in_w[s];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
         end else if (rdy && jump_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (pop_w[s])  head_q <= head_q + c_PTR_ONE;
            if (push_w[s]) tail_q <= tail_q + c_PTR_ONE;
            case ({push_w[s], pop_w[s]})
               2'b10:   cnt_q <= cnt_q + c_CNT_ONE;
               2'b01:   cnt_q <= cnt_q - c_CNT_ONE;
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end

   always_comb begin
      active_w = rdy & ~jump_rst;
      cand_w   = active_w ? (has_w | send_w) : 2'b00;
      if (cand_w == 2'b11) grant_w = last_q ? 2'b01 : 2'b10;
      else                 grant_w = cand_w;
      pop_w      = grant_w & has_w;
      // A granted source with an empty FIFO bypasses its input; anything else valid is queued.
      push_req_w = active_w ? (send_w & ~(grant_w & ~has_w)) : 2'b00;
      push_w     = push_req_w & (~full_w | pop_w);
      drop_w     = push_req_w & full_w & ~pop_w;
      sel_w = grant_w[1] ? (has_w[1] ? head_w[1] : in_w[1])
                         : (has_w[0] ? head_w[0] : in_w[0]);
      last_d = last_q;
      if (jump_rst)      last_d = 1'b1;
      else if (|grant_w) last_d = grant_w[1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_send_q    <= 1'b0;
         commit_value_q   <= '0;
         commit_reorder_q <= '0;
         overflow_q       <= 1'b0;
         last_q           <= 1'b1;
      end else if (rdy) begin
         commit_send_q <= |grant_w;
         if (|grant_w) {commit_value_q, commit_reorder_q} <= sel_w;
         if (|drop_w)  overflow_q <= 1'b1;
         last_q <= last_d;
      end else begin
         commit_send_q <= 1'b0;
      end
   end

   assign alu_full       = full_w[0];
   assign lsb_full       = full_w[1];
   assign commit_send    = commit_send_q;
   assign commit_value   = commit_value_q;
   assign commit_reorder = commit_reorder_q;
   assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_rst;
   logic        alu_send, lsb_send;
   logic [31:0] alu_value, lsb_value;
   logic [3:0]  alu_reorder, lsb_reorder;
   logic        alu_full, lsb_full, commit_send, overflow;
   logic [31:0] commit_value;
   logic [3:0]  commit_reorder;

   int n_checks = 0;
   int n_fails  = 0;

   cdb_arbiter #(.ROB_SIZE_LOG(4), .FIFO_DEPTH_LOG(2)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
      .alu_send(alu_send), .alu_value(alu_value), .alu_reorder(alu_reorder),
      .lsb_send(lsb_send), .lsb_value(lsb_value), .lsb_reorder(lsb_reorder),
      .alu_full(alu_full), .lsb_full(lsb_full),
      .commit_send(commit_send), .commit_value(commit_value),
      .commit_reorder(commit_reorder), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic as, input logic [31:0] av, input logic [3:0] at,
                        input logic ls, input logic [31:0] lv, input logic [3:0] lt);
      alu_send = as; alu_value = av; alu_reorder = at;
      lsb_send = ls; lsb_value = lv; lsb_reorder = lt;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic expect_bc(input string tag, input logic s, input logic [31:0] v, input logic [3:0] t);
      check_eq({tag, "_send"}, commit_send, s);
      if (s) begin
         check_eq({tag, "_value"}, commit_value, v);
         check_eq({tag, "_tag"}, commit_reorder, t);
      end
   endtask

   task automatic reset_dut();
      idle();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   logic [31:0] qa[$];
   logic [31:0] ql[$];

   task automatic score(input string tag);
      logic [31:0] e;
      logic        is_alu;
      is_alu = (commit_value[31:28] == 4'hA);
      if (is_alu) begin
         check_eq({tag, "_alu_pending"}, qa.size() > 0, 1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            check_eq({tag, "_alu_value"}, commit_value, e);
            check_eq({tag, "_alu_tag"}, commit_reorder, e[3:0]);
         end
      end else begin
         check_eq({tag, "_lsb_pending"}, ql.size() > 0, 1);
         if (ql.size() > 0) begin
            e = ql.pop_front();
            check_eq({tag, "_lsb_value"}, commit_value, e);
            check_eq({tag, "_lsb_tag"}, commit_reorder, e[3:0] ^ 4'h8);
         end
      end
   endtask

   initial begin
      logic prev_alu;
      logic saw_full;
      int   na, nl;
      rdy = 1'b1; jump_rst = 1'b0; idle();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      expect_bc("rst0", 1'b0, 32'h0, 4'h0);
      check_eq("rst0_value", commit_value, 32'h0);
      check_eq("rst0_tag", commit_reorder, 4'h0);
      check_eq("rst0_ovf", overflow, 1'b0);
      check_eq("rst0_full", {alu_full, lsb_full}, 2'b00);
      tick();
      rst = 1'b1;

      // single result, one-cycle latency
      drive(1'b1, 32'h12345678, 4'd3, 1'b0, 32'h0, 4'h0);
      tick();
      expect_bc("single", 1'b1, 32'h12345678, 4'd3);
      idle();
      tick();
      check_eq("single_done", commit_send, 1'b0);
      check_eq("single_hold", commit_value, 32'h12345678);

      // contention and round-robin
      reset_dut();
      drive(1'b1, 32'hA, 4'd5, 1'b1, 32'hB, 4'd6);
      tick();
      expect_bc("cont1", 1'b1, 32'hA, 4'd5);
      drive(1'b1, 32'hC, 4'd7, 1'b1, 32'hD, 4'd8);
      tick();
      expect_bc("cont2", 1'b1, 32'hB, 4'd6);
      idle();
      tick();
      expect_bc("cont3", 1'b1, 32'hC, 4'd7);
      tick();
      expect_bc("cont4", 1'b1, 32'hD, 4'd8);
      tick();
      expect_bc("cont5", 1'b0, 32'h0, 4'h0);

      // sustained traffic with full gating
      reset_dut();
      na = 0; nl = 0; saw_full = 1'b0; prev_alu = 1'b0;
      for (int c = 0; c < 20; c++) begin
         idle();
         if (!alu_full) begin
            alu_send = 1'b1; alu_value = 32'hA000_0000 | na; alu_reorder = 4'(na);
            qa.push_back(alu_value); na++;
         end
         if (!lsb_full) begin
            lsb_send = 1'b1; lsb_value = 32'hB000_0000 | nl; lsb_reorder = 4'(nl) ^ 4'h8;
            ql.push_back(lsb_value); nl++;
         end
         tick();
         if (alu_full) saw_full = 1'b1;
         check_eq("sus_send", commit_send, 1'b1);
         if (commit_send) begin
            score("sus");
            if (c > 0) check_eq("sus_alternate", commit_value[31:28] == 4'hA, !prev_alu);
            prev_alu = (commit_value[31:28] == 4'hA);
         end
      end
      idle();
      for (int c = 0; c < 16; c++) begin
         tick();
         if (commit_send) score("drain");
      end
      check_eq("sus_alu_left", qa.size(), 0);
      check_eq("sus_lsb_left", ql.size(), 0);
      check_eq("sus_saw_full", saw_full, 1'b1);
      check_eq("sus_ovf", overflow, 1'b0);

      // flush with 3 ALU + 2 LSB entries queued
      reset_dut();
      drive(1'b1, 32'h101, 4'd1, 1'b1, 32'h109, 4'd9);  tick(); expect_bc("fl1", 1'b1, 32'h101, 4'd1);
      drive(1'b1, 32'h102, 4'd2, 1'b1, 32'h10A, 4'd10); tick(); expect_bc("fl2", 1'b1, 32'h109, 4'd9);
      drive(1'b1, 32'h103, 4'd3, 1'b1, 32'h10B, 4'd11); tick(); expect_bc("fl3", 1'b1, 32'h102, 4'd2);
      drive(1'b1, 32'h104, 4'd4, 1'b1, 32'h10C, 4'd12); tick(); expect_bc("fl4", 1'b1, 32'h10A, 4'd10);
      drive(1'b1, 32'h105, 4'd5, 1'b1, 32'h10D, 4'd13); tick(); expect_bc("fl5", 1'b1, 32'h103, 4'd3);
      drive(1'b1, 32'h106, 4'd6, 1'b0, 32'h0, 4'd0);    tick(); expect_bc("fl6", 1'b1, 32'h10B, 4'd11);
      drive(1'b1, 32'h107, 4'd7, 1'b0, 32'h0, 4'd0);
      jump_rst = 1'b1;
      tick();
      jump_rst = 1'b0;
      check_eq("flush_send", commit_send, 1'b0);
      check_eq("flush_full", {alu_full, lsb_full}, 2'b00);
      drive(1'b1, 32'h77, 4'd14, 1'b0, 32'h0, 4'd0);
      tick();
      expect_bc("flush_new", 1'b1, 32'h77, 4'd14);
      idle();
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq("flush_quiet", commit_send, 1'b0);
      end

      // overflow: ALU fills while LSB takes alternate grants
      reset_dut();
      for (int c = 1; c <= 10; c++) begin
         drive(1'b1, 32'hA000_0000 | c, 4'(c), !lsb_full, 32'hB000_0000 | c, 4'(c));
         tick();
         if (c == 7) check_eq("ovf_notfull7", alu_full, 1'b0);
         if (c == 8) check_eq("ovf_full8", alu_full, 1'b1);
         if (c == 9) check_eq("ovf_clear9", overflow, 1'b0);
         if (c == 10) check_eq("ovf_set10", overflow, 1'b1);
      end
      idle();
      jump_rst = 1'b1;
      tick();
      jump_rst = 1'b0;
      check_eq("ovf_sticky", overflow, 1'b1);
      check_eq("ovf_flush_full", alu_full, 1'b0);

      // stall with rdy low
      drive(1'b1, 32'h101, 4'd1, 1'b1, 32'h109, 4'd9);  tick(); expect_bc("st1", 1'b1, 32'h101, 4'd1);
      drive(1'b1, 32'h102, 4'd2, 1'b1, 32'h10A, 4'd10); tick(); expect_bc("st2", 1'b1, 32'h109, 4'd9);
      drive(1'b1, 32'h103, 4'd3, 1'b1, 32'h10B, 4'd11); tick(); expect_bc("st3", 1'b1, 32'h102, 4'd2);
      drive(1'b1, 32'hDEAD, 4'd15, 1'b1, 32'hBEEF, 4'd14);
      rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("stall_send", commit_send, 1'b0);
         check_eq("stall_hold", commit_value, 32'h102);
      end
      rdy = 1'b1;
      idle();
      tick(); expect_bc("res1", 1'b1, 32'h10A, 4'd10);
      tick(); expect_bc("res2", 1'b1, 32'h103, 4'd3);
      tick(); expect_bc("res3", 1'b1, 32'h10B, 4'd11);
      tick(); expect_bc("res4", 1'b0, 32'h0, 4'h0);

      // asynchronous reset mid-traffic
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 32'h201 + c, 4'(c), 1'b1, 32'h301 + c, 4'(c + 8));
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      check_eq("arst_send", commit_send, 1'b0);
      check_eq("arst_value", commit_value, 32'h0);
      check_eq("arst_tag", commit_reorder, 4'h0);
      check_eq("arst_ovf", overflow, 1'b0);
      check_eq("arst_full", {alu_full, lsb_full}, 2'b00);
      idle();
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("arst_stale", commit_send, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
